// File: rtl/cr_xp10_decomp_sdd_lane_sched.sv
// Dispatches framed 128-bit beats from the word feeder to one of two decode lanes,
// keeping per-lane busy state and a lane-order FIFO for the downstream output merger.
module cr_xp10_decomp_sdd_lane_sched #(
  parameter int ORD_DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wf_lanes_valid,
  input  logic [127:0] wf_lanes_data,
  input  logic [7:0]   wf_lanes_numbits,
  input  logic         wf_lanes_sob,
  input  logic         wf_lanes_eob,
  input  logic         wf_lanes_eof,
  input  logic         wf_lanes_trace_bit,
  output logic         lanes_wf_ready,
  output logic [1:0]   lane_valid,
  output logic [127:0] lane_data,
  output logic [7:0]   lane_numbits,
  output logic         lane_sob,
  output logic         lane_eob,
  output logic         lane_eof,
  output logic         lane_trace_bit,
  input  logic [1:0]   lane_ready,
  input  logic [1:0]   lane_done,
  output logic         ord_valid,
  output logic         ord_lane,
  input  logic         ord_ready,
  output logic         sched_err_stb,
  output logic         sched_stall_stb
);

  localparam int AW = $clog2(ORD_DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  typedef enum logic {IDLE, STREAM} state_t;

  state_t               state, state_nxt;
  logic [1:0]           busy, busy_nxt;
  logic                 rr_ptr, rr_nxt;
  logic                 cur_lane, cur_nxt;
  logic [AW:0]          wr_ptr, rd_ptr;
  logic [ORD_DEPTH-1:0] ord_mem;
  logic                 sel, sel_ok, push, pop, fifo_full;
  logic                 err_nxt, rdy;
  logic [1:0]           lv;

  assign lane_data      = wf_lanes_data;
  assign lane_numbits   = wf_lanes_numbits;
  assign lane_sob       = wf_lanes_sob;
  assign lane_eob       = wf_lanes_eob;
  assign lane_eof       = wf_lanes_eof;
  assign lane_trace_bit = wf_lanes_trace_bit;

  assign fifo_full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign ord_valid = (wr_ptr != rd_ptr);
  assign ord_lane  = ord_mem[rd_ptr[AW-1:0]];
  assign pop       = ord_valid && ord_ready;

  // Handshake outputs are forced low while reset is held.
  assign lanes_wf_ready = rdy & rst_n;
  assign lane_valid     = lv & {2{rst_n}};

  always_comb begin
    state_nxt = state;
    busy_nxt  = busy;
    rr_nxt    = rr_ptr;
    cur_nxt   = cur_lane;
    sel       = rr_ptr;
    sel_ok    = 1'b0;
    push      = 1'b0;
    err_nxt   = 1'b0;
    rdy       = 1'b0;
    lv        = 2'b00;

    if (!busy[rr_ptr]) begin
      sel    = rr_ptr;
      sel_ok = !fifo_full;
    end else if (!busy[~rr_ptr]) begin
      sel    = ~rr_ptr;
      sel_ok = !fifo_full;
    end

    // Completion pulses free lanes; a dispatch below may set the other lane in the same cycle.
    for (int i = 0; i < 2; i++) begin
      if (lane_done[i]) begin
        if (busy[i]) busy_nxt[i] = 1'b0;
        else         err_nxt     = 1'b1;
      end
    end

    case (state)
      IDLE: begin
        if (wf_lanes_sob) begin
          if (sel_ok) begin
            rdy     = lane_ready[sel];
            lv[sel] = wf_lanes_valid;
            if (wf_lanes_valid && rdy) begin
              busy_nxt[sel] = 1'b1;
              push          = 1'b1;
              rr_nxt        = ~sel;
              cur_nxt       = sel;
              if (!(wf_lanes_eob || wf_lanes_eof)) state_nxt = STREAM;
            end
          end
        end else begin
          rdy = 1'b1;
          if (wf_lanes_valid) err_nxt = 1'b1;
        end
      end
      STREAM: begin
        rdy          = lane_ready[cur_lane];
        lv[cur_lane] = wf_lanes_valid;
        if (wf_lanes_valid && rdy) begin
          if (wf_lanes_sob) err_nxt = 1'b1;
          if (wf_lanes_eob || wf_lanes_eof) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      busy            <= 2'b00;
      rr_ptr          <= 1'b0;
      cur_lane        <= 1'b0;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      sched_err_stb   <= 1'b0;
      sched_stall_stb <= 1'b0;
    end else begin
      state           <= state_nxt;
      busy            <= busy_nxt;
      rr_ptr          <= rr_nxt;
      cur_lane        <= cur_nxt;
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      sched_err_stb   <= err_nxt;
      sched_stall_stb <= wf_lanes_valid && !lanes_wf_ready && wf_lanes_trace_bit;
    end
  end

  // Order storage holds data only; validity comes from the pointers.
  always_ff @(posedge clk) begin
    if (push) ord_mem[wr_ptr[AW-1:0]] <= sel;
  end

endmodule

// File: doc/cr_xp10_decomp_sdd_lane_sched.md
CR_XP10_DECOMP_SDD_LANE_SCHED -- requirements
Module: cr_xp10_decomp_sdd_lane_sched

Interface
REQ-001 SHALL have parameter ORD_DEPTH, default 4, meaning depth of the lane-order FIFO (power of 2, range 2..16).
REQ-002 SHALL have ports clk (input, 1, clock) and rst_n (input, 1, reset): one clock; reset is asynchronous and active-low.
REQ-003 SHALL have port wf_lanes_valid (input, 1): packed 128-bit beat valid from the word feeder.
REQ-004 SHALL have port wf_lanes_data (input, 128): beat payload.
REQ-005 SHALL have port wf_lanes_numbits (input, 8): valid bits in the beat, 1..128.
REQ-006 SHALL have ports wf_lanes_sob, wf_lanes_eob, wf_lanes_eof, wf_lanes_trace_bit (input, 1 each): block and frame markers, trace.
REQ-007 SHALL have port lanes_wf_ready (output, 1): beat accepted when high with wf_lanes_valid.
REQ-008 SHALL have port lane_valid (output, 2): per-decode-lane beat valid, at most one bit high.
REQ-009 SHALL have ports lane_data (output, 128), lane_numbits (output, 8), lane_sob, lane_eob, lane_eof, lane_trace_bit (output, 1 each): beat broadcast to both lanes.
REQ-010 SHALL have port lane_ready (input, 2): per-lane ready.
REQ-011 SHALL have port lane_done (input, 2): one-cycle pulse, lane finished decoding its block.
REQ-012 SHALL have ports ord_valid (output, 1), ord_lane (output, 1), ord_ready (input, 1): lane-order FIFO read side for the output merger.
REQ-013 SHALL have ports sched_err_stb (output, 1) and sched_stall_stb (output, 1): registered one-cycle pulses.

Function
REQ-014 SHALL implement FSM states IDLE (awaiting sob) and STREAM (locked to one lane, cur_lane).
REQ-015 SHALL keep per-lane busy flags; lane i busy from acceptance of its sob beat until its lane_done pulse.
REQ-016 In IDLE with wf_lanes_valid && wf_lanes_sob SHALL select a non-busy lane, preferring lane rr_ptr; if both are free, pick rr_ptr; if neither is free or the order FIFO is full, hold lanes_wf_ready=0 and lane_valid=0.
REQ-017 Selection, lane_valid and lanes_wf_ready SHALL be combinational from registered state (zero-cycle pass-through); lanes_wf_ready = lane_ready[selected lane].
REQ-018 On sob beat acceptance SHALL: set busy[sel], push sel into order FIFO, set rr_ptr = ~sel, set cur_lane = sel, go to STREAM unless the beat also has eob or eof (single-beat block stays in IDLE).
REQ-019 In STREAM SHALL forward beats only to cur_lane with lanes_wf_ready = lane_ready[cur_lane]; return to IDLE on acceptance of a beat with eob or eof.
REQ-020 In IDLE a valid beat without sob SHALL be dropped (lanes_wf_ready=1, lane_valid=0), with sched_err_stb pulsed the next cycle.
REQ-021 In STREAM a beat with sob SHALL be forwarded to cur_lane unchanged, with sched_err_stb pulsed.
REQ-022 lane_done on a non-busy lane SHALL be ignored, with sched_err_stb pulsed; lane_done on a lane in the same cycle as a sob dispatch to the other lane SHALL apply both updates.
REQ-023 Order FIFO: ORD_DEPTH entries, pointers one bit wider than log2(ORD_DEPTH), wrap-around, full when pointers differ only in MSB; simultaneous push and pop when full SHALL be disallowed by REQ-016; simultaneous push and pop when empty SHALL make ord_valid high next cycle only.
REQ-024 sched_stall_stb SHALL be registered wf_lanes_valid && !lanes_wf_ready && wf_lanes_trace_bit.
REQ-025 lane_data and the marker outputs SHALL equal the wf_lanes inputs at all times.

Reset
REQ-026 On rst_n low SHALL asynchronously set: state=IDLE, busy=0, rr_ptr=0, cur_lane=0, FIFO pointers=0, ord_valid=0, sched_err_stb=0, sched_stall_stb=0; lane_valid=0 and lanes_wf_ready=0 while in reset.
REQ-027 Reset mid-block SHALL discard in-flight state; the next accepted beat must carry sob.

Verification
REQ-028 Two 3-beat blocks (sob, mid, eob), lanes free, ready=1 -> block A to lane 0, block B to lane 1, ord reads 0 then 1.
REQ-029 Both lanes busy, third sob presented -> lanes_wf_ready=0 until lane_done[0] pulse; dispatched to lane 0 the cycle after the pulse.
REQ-030 Single beat with sob=eob=1, numbits=17 -> one lane_valid cycle, FSM stays IDLE, busy set, one FIFO entry.
REQ-031 Beat with no sob in IDLE -> dropped, sched_err_stb=1 one cycle later; lane_done[1] while lane 1 is idle -> sched_err_stb pulse, no state change.
REQ-032 ORD_DEPTH=4, ord_ready=0, 4 single-beat blocks with lane_done returned -> 5th sob stalls until one ord pop.
REQ-033 rst_n asserted in STREAM after 2 beats -> all outputs at reset values; next sob goes to lane 0.
